// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: state encoding and counter widths shared by the IF-stage sequencing controller.
// Rev 1.0
`default_nettype none

package fetch_ctrl_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    INIT  = ST_INIT,
    RUN   = ST_RUN,
    REDIR = ST_REDIR,
    HALT  = ST_HALT
  } state_t;

  // Redirect bubble counter covers 0..15; reset hold counter covers 0..255.
  localparam int BUB_W  = 4;
  localparam int HOLD_W = 8;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_perf.sv
// fetch_ctrl_perf: saturating load-use stall and redirect/jump flush event counters.
// Rev 1.0
`default_nettype none

module fetch_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencing controller (reset hold-off, redirect, jump, load-use, debug halt).
// FETCH_PERF_EN enables saturating stall/flush counters. Rev 1.0
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int RESET_HOLD       = 2,
  parameter int REDIRECT_BUBBLES = 0,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jump_dec,
  input  logic             halt_req,
  input  logic             resume,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Jump,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [BUB_W-1:0]  BUB_INIT  = BUB_W'(REDIRECT_BUBBLES);

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [BUB_W-1:0]  bub_cnt, bub_next;
  logic              halt_pend, halt_pend_next;
  logic              stall_ev, flush_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      hold_cnt  <= HOLD_INIT;
      bub_cnt   <= '0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      bub_cnt   <= bub_next;
      halt_pend <= halt_pend_next;
    end
  end

  always_comb begin
    state_next     = state;
    hold_next      = hold_cnt;
    bub_next       = bub_cnt;
    halt_pend_next = halt_pend;
    PCWrite        = 1'b0;
    PCSrc          = 1'b0;
    Jump           = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    halted         = 1'b0;
    stall_ev       = 1'b0;
    flush_ev       = 1'b0;

    // Outputs are forced quiet for as long as reset is held.
    if (!rst) begin
      case (state)
        INIT: begin
          ifid_flush = 1'b1;
          if (hold_cnt <= HOLD_W'(1))
            state_next = RUN;
          else
            hold_next = hold_cnt - HOLD_W'(1);
        end

        RUN: begin
          if (branch_taken) begin
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_ev   = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
              state_next     = REDIR;
              bub_next       = BUB_INIT;
              halt_pend_next = halt_pend | halt_req;
            end else if (halt_req || halt_pend) begin
              state_next     = HALT;
              halt_pend_next = 1'b0;
            end
          end else if (jump_dec) begin
            Jump       = 1'b1;
            PCWrite    = 1'b1;
            ifid_flush = 1'b1;
            flush_ev   = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
            stall_ev   = 1'b1;
          end else begin
            PCWrite    = 1'b1;
            ifid_write = 1'b1;
            if (halt_req || halt_pend) begin
              state_next     = HALT;
              halt_pend_next = 1'b0;
            end
          end
        end

        REDIR: begin
          ifid_flush     = 1'b1;
          halt_pend_next = halt_pend | halt_req;
          if (branch_taken) begin
            // A fresh redirect restarts the bubble window at the new target.
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
            idex_flush = 1'b1;
            flush_ev   = 1'b1;
            bub_next   = BUB_INIT;
          end else if (bub_cnt <= BUB_W'(1)) begin
            if (halt_pend || halt_req) begin
              state_next     = HALT;
              halt_pend_next = 1'b0;
            end else begin
              state_next = RUN;
            end
          end else begin
            bub_next = bub_cnt - BUB_W'(1);
          end
        end

        HALT: begin
          halted     = 1'b1;
          ifid_flush = 1'b1;
          if (branch_taken) begin
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
            idex_flush = 1'b1;
            flush_ev   = 1'b1;
          end
          if (resume && !halt_req)
            state_next = RUN;
        end

        default: state_next = INIT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  fetch_ctrl_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (stall_ev),
    .flush_inc (flush_ev),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf = stall_ev ^ flush_ev;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

`default_nettype wire
